// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle control sequencer and the existing
// instruction decoder: the 3-bit state encoding, the RV32 major opcode
// constants, and the alu_op / wb_sel encodings driven to the datapath.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == OP_RTYPE)  || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_LUI)    || (op == OP_SYSTEM);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_retire_counter.sv
// Retired-instruction counter.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low clear
//   inc_en - add one on the next rising edge (wraps modulo 2^CNT_W)
//   count  - current count
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath controls.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   opcode             - instruction[6:0], sampled only in DECODE
//   mem_ready          - memory accepts/completes the request this cycle
//   branch_taken       - datapath compare result, used only in EXEC
//   mem_req, mem_we, addr_sel                  - memory interface controls
//   ir_write, pc_write, pc_sel                 - IR / PC update controls
//   alu_src, alu_op, reg_write, wb_sel         - datapath controls
//   illegal            - sticky: an undecodable opcode was seen
//   halted             - sequencer is in HALT (left only by reset)
//   retired            - count of completed instructions
//   state_dbg          - current FSM state, for observation only
//
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle where mem_req and mem_ready are both high, and the
// sequencer advances on that edge. mem_ready is ignored when mem_req is low.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  state_t     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;
  logic       retire_inc;

  logic       mem_req_c, mem_we_c, addr_sel_c, ir_write_c, pc_write_c;
  logic       pc_sel_c, alu_src_c, reg_write_c, halted_c;
  logic [1:0] alu_op_c, wb_sel_c;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    illegal_d   = illegal_q;
    retire_inc  = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = 1'b0;
    alu_src_c   = 1'b0;
    alu_op_c    = ALU_ADD;
    reg_write_c = 1'b0;
    wb_sel_c    = WB_ALU;
    halted_c    = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          // IR load and PC+4 update happen on the same accepting edge.
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Decisions here use the live opcode; later states use the copy.
        opcode_d = opcode;
        if (opcode == OP_SYSTEM) begin
          retire_inc = 1'b1;
          state_d    = ST_HALT;
        end else if (!is_legal_opcode(opcode)) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_src_c = (opcode_q == OP_IALU) || (opcode_q == OP_LOAD) ||
                    (opcode_q == OP_STORE) || (opcode_q == OP_LUI);
        if ((opcode_q == OP_RTYPE) || (opcode_q == OP_IALU)) alu_op_c = ALU_FUNCT;
        else if (opcode_q == OP_BRANCH)                      alu_op_c = ALU_CMP;
        else if (opcode_q == OP_LUI)                         alu_op_c = ALU_PASS;

        case (opcode_q)
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_BRANCH: begin
            pc_write_c = branch_taken;
            pc_sel_c   = branch_taken;
            retire_inc = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_JAL: begin
            pc_write_c = 1'b1;
            pc_sel_c   = 1'b1;
            state_d    = ST_WB;
          end
          default: state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = (opcode_q == OP_STORE);
        if (mem_ready) begin
          if (opcode_q == OP_STORE) begin
            retire_inc = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write_c = 1'b1;
        if (opcode_q == OP_LOAD)     wb_sel_c = WB_MEM;
        else if (opcode_q == OP_JAL) wb_sel_c = WB_PC4;
        retire_inc = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_HALT: halted_c = 1'b1;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
    end
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (retire_inc),
    .count  (retired)
  );

  // The reset state is FETCH, which would otherwise request memory while
  // reset is still held; gating the strobes keeps the bus quiet until release.
  assign mem_req   = mem_req_c   & rst_n;
  assign mem_we    = mem_we_c    & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign addr_sel  = addr_sel_c;
  assign pc_sel    = pc_sel_c;
  assign alu_src   = alu_src_c;
  assign alu_op    = alu_op_c;
  assign wb_sel    = wb_sel_c;
  assign halted    = halted_c;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int OW = 14;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, alu_src;
  logic [1:0]  alu_op, wb_sel;
  logic        reg_write, illegal, halted;
  logic [31:0] retired;
  logic [2:0]  state_dbg;

  multicycle_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
    .halted(halted), .retired(retired), .state_dbg(state_dbg)
  );

  logic [OW-1:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel,
                alu_src, alu_op, reg_write, wb_sel, illegal, halted};

  // scoreboard: per-cycle stimulus {opcode, mem_ready, branch_taken, completes}
  // and expected outputs, planned per instruction from the instruction rules
  logic [9:0]    stim_q[$];
  logic [OW-1:0] exp_q[$];
  string         tag_q[$];
  logic [31:0]   model_ret = '0;
  int            n_tests = 0;
  int            n_fail = 0;

  logic [6:0] legal_ops [7] = '{OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE,
                                OP_BRANCH, OP_JAL, OP_LUI};

  function automatic logic [OW-1:0] pk(
    input logic mr, input logic we, input logic as, input logic irw,
    input logic pcw, input logic pcs, input logic src, input logic [1:0] aop,
    input logic rw, input logic [1:0] wbs, input logic ill, input logic hlt);
    return {mr, we, as, irw, pcw, pcs, src, aop, rw, wbs, ill, hlt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic spec_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return op == OP_SYSTEM;
  endfunction

  // driver tasks
  task automatic push(input string t, input logic [6:0] op, input logic rdy,
                      input logic tk, input logic done, input logic [OW-1:0] e);
    stim_q.push_back({op, rdy, tk, done});
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check(input string t, input logic [OW-1:0] e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s outs=%b expected=%b", t, obs, e);
    end
    n_tests++;
    assert (retired === model_ret) else begin
      n_fail++;
      $error("FAIL %s_retired got=%0d expected=%0d", t, retired, model_ret);
    end
  endtask

  task automatic run(input int max_n);
    int k = 0;
    while (stim_q.size() > 0 && k < max_n) begin
      logic [9:0]    s;
      logic [OW-1:0] e;
      string         t;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clk);
      opcode       = s[9:3];
      mem_ready    = s[2];
      branch_taken = s[1];
      #1;
      check(t, e);
      if (s[0]) model_ret++;
      k++;
    end
  endtask

  task automatic plan_fetch(input int fw);
    for (int i = 0; i < fw; i++)
      push("fetch_wait", junk(), 1'b0, rb(), 1'b0, pk(1,0,0,0,0,0,0,2'b00,0,2'b00,0,0));
    push("fetch", junk(), 1'b1, rb(), 1'b0, pk(1,0,0,1,1,0,0,2'b00,0,2'b00,0,0));
  endtask

  // one legal, non-SYSTEM instruction
  task automatic plan_instr(input logic [6:0] op, input int fw, input int mw, input logic tk);
    logic       src, pcw, st, mem_op, has_wb;
    logic [1:0] aop, wbs;
    plan_fetch(fw);
    push("decode", op, rb(), rb(), 1'b0, '0);
    src = (op == OP_IALU) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_LUI);
    aop = (op == OP_RTYPE || op == OP_IALU) ? 2'b10 :
          (op == OP_BRANCH) ? 2'b01 : (op == OP_LUI) ? 2'b11 : 2'b00;
    pcw = (op == OP_JAL) || (op == OP_BRANCH && tk);
    push("exec", junk(), rb(), (op == OP_BRANCH) ? tk : rb(), op == OP_BRANCH,
         pk(0,0,0,0,pcw,pcw,src,aop,0,2'b00,0,0));
    st     = (op == OP_STORE);
    mem_op = (op == OP_LOAD) || st;
    if (mem_op) begin
      for (int i = 0; i < mw; i++)
        push("mem_wait", junk(), 1'b0, rb(), 1'b0, pk(1,st,1,0,0,0,0,2'b00,0,2'b00,0,0));
      push("mem", junk(), 1'b1, rb(), st, pk(1,st,1,0,0,0,0,2'b00,0,2'b00,0,0));
    end
    has_wb = (op != OP_BRANCH) && !st;
    if (has_wb) begin
      wbs = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL) ? 2'b10 : 2'b00;
      push("wb", junk(), rb(), rb(), 1'b1, pk(0,0,0,0,0,0,0,2'b00,1,wbs,0,0));
    end
  endtask

  // SYSTEM or illegal opcode, then a stretch of HALT cycles
  task automatic plan_halt(input logic [6:0] op, input int n_halt);
    logic sys;
    sys = (op == OP_SYSTEM);
    plan_fetch(int'($urandom_range(0, 2)));
    push("decode_halt", op, rb(), rb(), sys, '0);
    for (int i = 0; i < n_halt; i++)
      push("halt", junk(), rb(), rb(), 1'b0, pk(0,0,0,0,0,0,0,2'b00,0,2'b00,!sys,1));
  endtask

  task automatic do_reset();
    stim_q.delete();
    exp_q.delete();
    tag_q.delete();
    #1 rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    model_ret = '0;
    check("reset_async", '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_hold", '0);
    n_tests++;
    assert (state_dbg === ST_FETCH) else begin
      n_fail++;
      $error("FAIL reset_state got=%0d expected=%0d", state_dbg, ST_FETCH);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // ADD, no waits: 4 cycles, retired becomes 1
    plan_instr(OP_RTYPE, 0, 0, 1'b0);
    run(1000);
    // LW with 3 MEM wait cycles: 8 cycles total
    plan_instr(OP_LOAD, 0, 3, 1'b0);
    run(1000);
    // BEQ taken, then not taken
    plan_instr(OP_BRANCH, 0, 0, 1'b1);
    run(1000);
    plan_instr(OP_BRANCH, 1, 0, 1'b0);
    run(1000);
    plan_instr(OP_JAL, 0, 0, 1'b0);
    plan_instr(OP_LUI, 1, 0, 1'b0);
    plan_instr(OP_IALU, 0, 0, 1'b0);
    plan_instr(OP_STORE, 2, 1, 1'b0);
    run(1000);

    // SW: reset in the 2nd MEM wait cycle (fetch, decode, exec, wait1, wait2)
    plan_instr(OP_STORE, 0, 3, 1'b0);
    run(5);
    do_reset();
    plan_instr(OP_RTYPE, 0, 0, 1'b0);
    run(1000);

    // randomized legal instruction stream
    for (int n = 0; n < 150; n++) begin
      plan_instr(legal_ops[$urandom_range(0, 6)], int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), rb());
      run(1000);
    end

    // ECALL halts cleanly and counts as retired
    plan_halt(OP_SYSTEM, 20);
    run(1000);
    do_reset();

    // 7'b1111111 is illegal: sticky flag, no retire, no memory activity
    plan_instr(OP_LUI, 0, 0, 1'b0);
    plan_halt(7'b1111111, 20);
    run(1000);
    do_reset();

    // a few random illegal opcodes
    for (int n = 0; n < 4; n++) begin
      logic [6:0] op;
      op = junk();
      while (spec_legal(op)) op = junk();
      plan_instr(legal_ops[$urandom_range(0, 6)], 0, 0, rb());
      plan_halt(op, 5);
      run(1000);
      do_reset();
    end

    // final count check after the last reset release
    @(negedge clk);
    #1;
    n_tests++;
    assert (retired === model_ret) else begin
      n_fail++;
      $error("FAIL final_retired got=%0d expected=%0d", retired, model_ret);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 mem_ready  input  1  memory accepts or completes the current request this cycle.
REQ-006 branch_taken  input  1  branch compare result from the datapath, valid in EXEC.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  1 = store, 0 = read.
REQ-009 addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 ir_write  output  1  load the instruction register.
REQ-011 pc_write  output  1  update the PC.
REQ-012 pc_sel  output  1  PC source: 0 = PC+4, 1 = branch/jump target.
REQ-013 alu_src  output  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-014 alu_op  output  2  ALU function: 00 = add, 01 = compare, 10 = funct-decoded, 11 = pass immediate.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 wb_sel  output  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-017 illegal  output  1  sticky flag: an undecodable opcode was seen.
REQ-018 halted  output  1  sequencer is in HALT.
REQ-019 retired  output  CNT_W  count of completed instructions.

Function
REQ-020 States: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-021 Legal opcodes:
- R-type 0110011
- I-ALU 0010011
- LOAD 0000011
- STORE 0100011
- BRANCH 1100011
- JAL 1101111
- LUI 0110111
- SYSTEM 1110011
All other opcodes are illegal.
REQ-022 FETCH:
- mem_req=1, addr_sel=0, mem_we=0.
- On mem_ready=1: ir_write=1 and pc_write=1 with pc_sel=0 in that same cycle, then go to DECODE.
- Otherwise stay in FETCH with mem_req held.
REQ-023 DECODE:
- Latch opcode into an internal opcode register.
- SYSTEM goes to HALT.
- An illegal opcode sets illegal and goes to HALT.
- Any other opcode goes to EXEC.
REQ-024 EXEC, driven from the latched opcode:
- alu_src=1 for I-ALU, LOAD, STORE and LUI; 0 otherwise.
- alu_op: 10 for R-type and I-ALU, 01 for BRANCH, 11 for LUI, 00 otherwise.
REQ-025 EXEC transitions:
- LOAD and STORE go to MEM.
- BRANCH asserts pc_write=1, pc_sel=1 only if branch_taken=1, then goes to FETCH.
- JAL asserts pc_write=1, pc_sel=1, then goes to WB.
- R-type, I-ALU and LUI go to WB.
REQ-026 MEM:
- mem_req=1, addr_sel=1, mem_we=1 only for STORE.
- Stay in MEM while mem_ready=0.
- On mem_ready=1, STORE goes to FETCH and LOAD goes to WB.
REQ-027 WB:
- reg_write=1 for exactly one cycle.
- wb_sel=01 for LOAD, 10 for JAL, 00 otherwise.
- Then go to FETCH.
REQ-028 retired increments by 1 on each instruction completion:
- leaving WB;
- EXEC-to-FETCH (BRANCH);
- MEM-to-FETCH (STORE);
- DECODE-to-HALT for SYSTEM.
It wraps modulo 2^CNT_W and never increments for an illegal opcode.
REQ-029 HALT:
- halted=1; all strobes (mem_req, ir_write, pc_write, reg_write, mem_we) are 0.
- HALT is left only by reset.
REQ-030 Outputs not named for a state are 0 in that state.
REQ-031 No strobe is asserted in DECODE.
REQ-032 mem_req is never asserted in two consecutive instructions without an intervening DECODE.
REQ-033 mem_ready is ignored outside FETCH and MEM.

Reset
REQ-034 rst_n=0 takes effect immediately, independent of clk:
- state=FETCH, retired=0, illegal=0, opcode register=0.
- All strobes are 0 while reset is held.
REQ-035 Reset asserted mid-access (FETCH or MEM) drops mem_req within the same cycle; no partial write-back occurs.
REQ-036 After rst_n deasserts, the first rising edge begins a FETCH with mem_req=1.

Structure
REQ-037 A shared package holds:
- the state enumeration (3-bit);
- the opcode constants;
- the alu_op and wb_sel encodings.
The existing decoder uses the same package.
REQ-038 Sub-module: one, retire_counter (CNT_W-bit counter with increment enable and asynchronous active-low clear).
REQ-039 Next-state logic and output decode are combinational from the registered state and the latched opcode; only the state, opcode, illegal and counter registers are sequential.

Verification
REQ-040 ADD (0110011) with mem_ready=1 → FETCH, DECODE, EXEC, WB: 4 cycles, reg_write high 1 cycle with wb_sel=00, retired=1.
REQ-041 LW with mem_ready=0 for 3 MEM cycles → mem_req high 4 MEM cycles, addr_sel=1, mem_we=0, wb_sel=01 in WB, 8 cycles total.
REQ-042 BEQ with branch_taken=1 → pc_write=1, pc_sel=1 in EXEC, no reg_write; with branch_taken=0 → no pc_write in EXEC; both give retired+1.
REQ-043 Opcode 7'b1111111 → illegal=1, halted=1, no further mem_req for 20 cycles, retired unchanged.
REQ-044 rst_n=0 in the 2nd MEM wait cycle of SW → mem_req and mem_we go low before the next edge, retired=0, FETCH follows release.
REQ-045 ECALL (1110011) → HALT with illegal=0, halted=1, retired+1.
